// File: rtl/uart_tx.sv
// uart_tx
// -------
// 8N1 UART transmitter for the board side of the debug link. It accepts a
// one-cycle start strobe with a data word, then sends a start bit, NB_DATA
// data bits LSB first and a stop bit. A one-cycle done pulse is raised when
// the stop bit has completed. The baud tick is generated locally from the
// system clock so that bit timing matches the oversampling UART receiver.
//
// Ports:
//   i_clock     system clock
//   i_reset     synchronous, active-high reset
//   i_tx_start  one-cycle request to send i_tx_data (ignored while busy)
//   i_tx_data   word to send, captured only when a request is accepted
//   o_tx        serial line, idle high, driven straight from a flop
//   o_tx_done   one-cycle pulse in the first idle cycle after the stop bit
//   o_busy      high from the cycle after accept through the end of stop bit

module uart_tx #(
  parameter int NB_DATA    = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19_200,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy
);

  // Clocks per oversample tick, never allowed to fall below one.
  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  // The tick counter has to cover both data-bit and stop-bit lengths.
  localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   OVS_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0]   SB_LAST  = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [S_W-1:0]     s;
  logic [N_W-1:0]     n;
  logic [NB_DATA-1:0] shreg;
  logic [NB_DATA-1:0] shreg_next;
  logic               tick;

  // The divider sits at zero while idle, so the first tick of a frame lands
  // exactly DIV clocks after the accept and every bit has a fixed length.
  assign tick       = (div_cnt == DIV_LAST);
  assign shreg_next = shreg >> 1;

  // Divider, frame FSM and all outputs live in one registered block so the
  // serial line and the handshake outputs can never glitch. The done pulse
  // is asserted in the cycle the FSM returns to IDLE, and a request seen in
  // that same cycle is deliberately refused, which gives back-to-back frames
  // their one-cycle gap.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      s         <= '0;
      n         <= '0;
      shreg     <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;

      if (state == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (i_tx_start && !o_tx_done) begin
            shreg  <= i_tx_data;
            s      <= '0;
            n      <= '0;
            state  <= START;
            o_tx   <= 1'b0;
            o_busy <= 1'b1;
          end else begin
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
          end
        end

        START: begin
          if (tick) begin
            if (s == OVS_LAST) begin
              s     <= '0;
              state <= DATA;
              o_tx  <= shreg[0];
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (s == OVS_LAST) begin
              s     <= '0;
              shreg <= shreg_next;
              if (n == N_LAST) begin
                state <= STOP;
                o_tx  <= 1'b1;
              end else begin
                n    <= n + 1'b1;
                o_tx <= shreg_next[0];
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (s == SB_LAST) begin
              s         <= '0;
              state     <= IDLE;
              o_tx      <= 1'b1;
              o_busy    <= 1'b0;
              o_tx_done <= 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        default: begin
          state  <= IDLE;
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
